i2s_sample_fifo: RTL

Stereo sample buffer sitting directly upstream of the I2S master. It accepts left/right sample pairs from the player/decoder over a valid/ready port and stores them in a DEPTH-entry FIFO. It drives the I2S master's send/data/done handshake so that one stored pair is consumed per stereo frame. It also handles start-up priming, underrun (silence insertion), refill requests and flushing.

---
 rtl/i2s_sample_fifo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - stereo sample FIFO feeding the I2S master
//
// Purpose: buffers left/right sample pairs from the decoder and hands one
// pair to the I2S master per stereo frame, with start-up priming, silence
// insertion on underrun, refill requests and flushing.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   play_i, flush_i           play level, one-cycle flush pulse
//   wr_L_i, wr_R_i            sample pair to write
//   wr_valid_i, wr_ready_o    write handshake (ready = not full)
//   i2s_sample_data_L/R_o     head pair presented to the I2S master
//   i2s_send_o, i2s_done_i    I2S master handshake
//   level_o                   stored pairs, 0..DEPTH
//   refill_req_o              level below REFILL_LEVEL
//   underrun_o                sticky underrun flag
//   underrun_cnt_o            saturating underrun counter
module i2s_sample_fifo #(
  parameter int DATA_BITS    = 16,
  parameter int DEPTH        = 16,
  parameter int START_LEVEL  = 8,
  parameter int REFILL_LEVEL = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         play_i,
  input  logic                         flush_i,
  input  logic [DATA_BITS-1:0]         wr_L_i,
  input  logic [DATA_BITS-1:0]         wr_R_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  output logic [DATA_BITS-1:0]         i2s_sample_data_L_o,
  output logic [DATA_BITS-1:0]         i2s_sample_data_R_o,
  output logic                         i2s_send_o,
  input  logic                         i2s_done_i,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         refill_req_o,
  output logic                         underrun_o,
  output logic [15:0]                  underrun_cnt_o
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  localparam logic [ADDR_BITS:0]   LVL_FULL   = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   LVL_START  = (ADDR_BITS+1)'(START_LEVEL);
  localparam logic [ADDR_BITS:0]   LVL_REFILL = (ADDR_BITS+1)'(REFILL_LEVEL);
  localparam logic [ADDR_BITS:0]   LVL_ONE    = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

  logic [2*DATA_BITS-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0]   r_wr_ptr;
  logic [ADDR_BITS-1:0]   r_rd_ptr;
  logic [ADDR_BITS:0]     r_level;
  logic [1:0]             r_state;
  logic                   r_underrun;
  logic [15:0]            r_underrun_cnt;

  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fe;
  logic                   w_underrun_evt;
  logic                   w_show;
  logic [1:0]             w_state_nxt;
  logic [2*DATA_BITS-1:0] w_head;

  assign w_empty    = (r_level == '0);
  assign wr_ready_o = (r_level != LVL_FULL);
  // Flush discards any write or read in the same cycle.
  assign w_push     = wr_valid_i & wr_ready_o & ~flush_i;
  assign w_fe       = (r_state == ST_PLAY) & i2s_done_i;
  assign w_pop      = w_fe & ~w_empty & ~flush_i;
  // Frame with nothing stored: outputs are already zero, so silence goes out.
  assign w_underrun_evt = w_fe & w_empty & ~flush_i;

  assign w_show              = (r_state == ST_PLAY) & ~w_empty;
  assign w_head              = r_mem[r_rd_ptr];
  assign i2s_sample_data_L_o = w_show ? w_head[2*DATA_BITS-1:DATA_BITS] : '0;
  assign i2s_sample_data_R_o = w_show ? w_head[DATA_BITS-1:0] : '0;
  assign i2s_send_o          = (r_state == ST_PLAY);
  assign level_o             = r_level;
  assign refill_req_o        = (r_level < LVL_REFILL);
  assign underrun_o          = r_underrun;
  assign underrun_cnt_o      = r_underrun_cnt;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ((r_state != ST_IDLE) && play_i) ? ST_PRIME : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (play_i) w_state_nxt = ST_PRIME;
        // Stop has priority over starting playback.
        ST_PRIME: if (!play_i) w_state_nxt = ST_IDLE;
                  else if (r_level >= LVL_START) w_state_nxt = ST_PLAY;
        ST_PLAY:  if (!play_i) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_L_i, wr_R_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_underrun <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
        else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
        if (w_underrun_evt) begin
          r_underrun <= 1'b1;
          if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
      end
    end
  end

endmodule
